convolve_pipe: RTL and testbench

//  Parametrised, fully pipelined KxK convolution MAC; successor to the single-shot 3x3 convolver.

---
 rtl/convolve_pipe.sv | 180 ++++++++++++++++++
 tb/tb_convolve_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/convolve_pipe.sv
// rtl/convolve_pipe.sv - pipelined KxK convolution MAC with round/saturate; CONV_RELU_EN clamps negatives to 0
module convolve_pipe #(
   parameter int FILTER_SIZE  = 3,
   parameter int DATA_W       = 8,
   parameter int COEF_W       = 8,
   parameter int OUT_W        = 16,
   parameter int SHIFT        = 0,
   parameter int IMAGE_WIDTH  = 9,
   parameter int IMAGE_HEIGHT = 9
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        filt_load,
   input  logic [FILTER_SIZE*FILTER_SIZE*COEF_W-1:0]   filt_in,
   input  logic                                        win_valid,
   output logic                                        win_ready,
   input  logic [FILTER_SIZE*FILTER_SIZE*DATA_W-1:0]   window_in,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [OUT_W-1:0]                            result,
   output logic                                        out_last,
   output logic                                        sat_flag
);

   localparam int K         = FILTER_SIZE;
   localparam int NE        = K * K;
   localparam int PROD_W    = DATA_W + COEF_W + 1;
   localparam int ACC_W     = PROD_W + $clog2(NE);
   localparam int FRAME_LEN = (IMAGE_WIDTH - K + 1) * (IMAGE_HEIGHT - K + 1);
   localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   // Output range and round-half-up constant, held one bit wider than the accumulator
   // so the rounding add can never wrap.
   localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((longint'(1) <<< (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;
   localparam logic signed [ACC_W:0] RND_C =
      (SHIFT > 0) ? (ACC_W+1)'(longint'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

   // Coefficient register
   logic [NE*COEF_W-1:0] coef_q;

   // Stage 1: per-element products
   logic signed [PROD_W-1:0] prod_d [NE];
   logic signed [PROD_W-1:0] prod_q [NE];
   logic                     v1_q;

   // Stage 2: per-row partial sums (splits the adder tree)
   logic signed [ACC_W-1:0]  row_d [K];
   logic signed [ACC_W-1:0]  row_q [K];
   logic                     v2_q;

   // Stage 3: full-precision accumulator
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  acc_q;
   logic                     v3_q;

   // Output stage: rounded, shifted, clipped result
   logic signed [ACC_W:0]    rnd_d;
   logic signed [ACC_W:0]    shf_d;
   logic [OUT_W-1:0]         res_d;
   logic                     sat_d;
   logic [OUT_W-1:0]         result_q;
   logic                     sat_q;
   logic                     out_valid_q;

   logic [CNT_W-1:0]         cnt_q;
   logic                     stall;
   logic                     advance;

   assign stall     = out_valid_q && !out_ready;
   assign advance   = !stall;
   assign win_ready = !stall;

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign sat_flag  = sat_q;
   assign out_last  = out_valid_q && (cnt_q == LAST_CNT);

   // Zero-extended pixel times sign-extended coefficient, using the coefficients held before this edge
   always_comb begin
      for (int i = 0; i < NE; i++) begin
         prod_d[i] = $signed(PROD_W'(window_in[i*DATA_W +: DATA_W]))
                   * $signed(PROD_W'($signed(coef_q[i*COEF_W +: COEF_W])));
      end
   end

   // Sign-extended sum of each kernel row
   always_comb begin
      for (int r = 0; r < K; r++) begin
         row_d[r] = '0;
         for (int c = 0; c < K; c++) begin
            row_d[r] = row_d[r] + ACC_W'(prod_q[r*K + c]);
         end
      end
   end

   // Sum of the row partials into the full-precision accumulator
   always_comb begin
      acc_d = '0;
      for (int r = 0; r < K; r++) begin
         acc_d = acc_d + row_q[r];
      end
   end

   // Round half up, arithmetic shift, clip to the output range, optional negative clamp
   always_comb begin
      rnd_d = (ACC_W+1)'(acc_q) + RND_C;
      shf_d = rnd_d >>> SHIFT;
      sat_d = 1'b0;
      res_d = shf_d[OUT_W-1:0];
      if (shf_d > MAX_V) begin
         res_d = MAX_V[OUT_W-1:0];
         sat_d = 1'b1;
      end else if (shf_d < MIN_V) begin
         res_d = MIN_V[OUT_W-1:0];
         sat_d = 1'b1;
      end
`ifdef CONV_RELU_EN
      if (res_d[OUT_W-1]) begin
         res_d = '0;
      end
`else
`endif
   end

   // Coefficient load; honoured even while the pipeline is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         coef_q <= '0;
      end else if (filt_load) begin
         coef_q <= filt_in;
      end
   end

   // Stage valid bits and output registers; everything holds while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         sat_q       <= 1'b0;
      end else if (advance) begin
         v1_q        <= win_valid;
         v2_q        <= v1_q;
         v3_q        <= v2_q;
         out_valid_q <= v3_q;
         if (v3_q) begin
            result_q <= res_d;
            sat_q    <= sat_d;
         end
      end
   end

   // Datapath registers; contents are only meaningful where the matching valid bit is set
   always_ff @(posedge clk) begin
      if (advance) begin
         prod_q <= prod_d;
         row_q  <= row_d;
         acc_q  <= acc_d;
      end
   end

   // Frame position counter, advanced per output transfer and wrapped after the last result
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (out_valid_q && out_ready) begin
         if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_convolve_pipe.sv
// tb/tb_convolve_pipe.sv - directed table-driven bench for convolve_pipe
module tb_convolve_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        filt_load = 1'b0;
   logic [71:0] filt_in = '0;
   logic        win_valid = 1'b0;
   logic [71:0] window_in = '0;
   logic        out_ready = 1'b0;

   logic        win_ready_a, out_valid_a, out_last_a, sat_a;
   logic [15:0] result_a;
   logic        win_ready_b, out_valid_b, out_last_b, sat_b;
   logic [7:0]  result_b;
   logic        win_ready_c, out_valid_c, out_last_c, sat_c;
   logic [15:0] result_c;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   convolve_pipe u_a (
      .clk(clk), .rst(rst), .filt_load(filt_load), .filt_in(filt_in),
      .win_valid(win_valid), .win_ready(win_ready_a), .window_in(window_in),
      .out_valid(out_valid_a), .out_ready(out_ready), .result(result_a),
      .out_last(out_last_a), .sat_flag(sat_a)
   );

   convolve_pipe #(.OUT_W(8)) u_b (
      .clk(clk), .rst(rst), .filt_load(filt_load), .filt_in(filt_in),
      .win_valid(win_valid), .win_ready(win_ready_b), .window_in(window_in),
      .out_valid(out_valid_b), .out_ready(out_ready), .result(result_b),
      .out_last(out_last_b), .sat_flag(sat_b)
   );

   convolve_pipe #(.SHIFT(2)) u_c (
      .clk(clk), .rst(rst), .filt_load(filt_load), .filt_in(filt_in),
      .win_valid(win_valid), .win_ready(win_ready_c), .window_in(window_in),
      .out_valid(out_valid_c), .out_ready(out_ready), .result(result_c),
      .out_last(out_last_c), .sat_flag(sat_c)
   );

   typedef struct {
      logic [71:0] coef;
      logic [71:0] pix;
      int          exp_a;
      bit          sat_a;
      int          exp_b;
      bit          sat_b;
      int          exp_c;
      bit          sat_c;
   } vec_t;

   vec_t vecs [12];

   function automatic logic [71:0] fill(input int v);
      logic [71:0] r;
      for (int i = 0; i < 9; i++) r[i*8 +: 8] = v[7:0];
      return r;
   endfunction

   function automatic logic [71:0] centre(input int v);
      logic [71:0] r;
      r = '0;
      r[32 +: 8] = v[7:0];
      return r;
   endfunction

   function automatic int relu(input int v);
`ifdef CONV_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; win_valid = 1'b0; filt_load = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic load_coef(input logic [71:0] c);
      @(posedge clk); #1;
      filt_in = c; filt_load = 1'b1;
      @(posedge clk); #1;
      filt_load = 1'b0;
   endtask

   task automatic apply_vec(input int idx);
      int lat;
      vec_t v;
      v = vecs[idx];
      load_coef(v.coef);
      out_ready = 1'b1;
      window_in = v.pix; win_valid = 1'b1;
      @(posedge clk); #1;
      win_valid = 1'b0;
      lat = 0;
      while (!out_valid_a && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("v%0d latency", idx), lat, 3);
      chk($sformatf("v%0d res_a", idx), int'($signed(result_a)), relu(v.exp_a));
      chk($sformatf("v%0d sat_a", idx), int'(sat_a), int'(v.sat_a));
      chk($sformatf("v%0d res_b", idx), int'($signed(result_b)), relu(v.exp_b));
      chk($sformatf("v%0d sat_b", idx), int'(sat_b), int'(v.sat_b));
      chk($sformatf("v%0d res_c", idx), int'($signed(result_c)), relu(v.exp_c));
      chk($sformatf("v%0d sat_c", idx), int'(sat_c), int'(v.sat_c));
      chk($sformatf("v%0d last_a", idx), int'(out_last_a), 0);
      @(posedge clk); #1;
   endtask

   // Window k is all pixels k with all-one coefficients, so its result is 9*k.
   // out_ready is high on every period-th cycle.
   task automatic run_stream(input int n, input int period);
      int sent, recv, cyc;
      bit prev_stall, acc, xfer;
      logic [15:0] held;
      sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; held = '0;
      while (recv < n && cyc < 1000) begin
         out_ready = ((cyc % period) == 0);
         win_valid = (sent < n);
         window_in = fill(sent);
         #1;
         if (prev_stall) begin
            chk("stall hold valid", int'(out_valid_a), 1);
            chk("stall hold result", int'(result_a), int'(held));
         end
         chk("win_ready", int'(win_ready_a), int'(!(out_valid_a && !out_ready)));
         xfer = out_valid_a && out_ready;
         if (xfer) begin
            chk($sformatf("stream res %0d", recv), int'($signed(result_a)), relu(9 * recv));
            chk($sformatf("stream last %0d", recv), int'(out_last_a), int'((recv % 49) == 48));
         end
         acc = win_valid && win_ready_a;
         prev_stall = out_valid_a && !out_ready;
         held = result_a;
         @(posedge clk); #1;
         sent += int'(acc);
         recv += int'(xfer);
         cyc++;
      end
      win_valid = 1'b0;
      chk("stream count", recv, n);
   endtask

   initial begin
      logic [71:0] mc, mp;
      int got [2];
      int ng, cyc;
      bit stale;

      mc = '0; mp = '0;
      for (int i = 0; i < 9; i++) begin
         mc[i*8 +: 8] = 8'(i - 4);
         mp[i*8 +: 8] = 8'(10 * i);
      end
      vecs[0]  = '{fill(1),     fill(255), 2295,   1'b0, 127,  1'b1, 574,    1'b0};
      vecs[1]  = '{centre(-128), fill(255), -32640, 1'b0, -128, 1'b1, -8160,  1'b0};
      vecs[2]  = '{centre(10),  fill(1),   10,     1'b0, 10,   1'b0, 3,      1'b0};
      vecs[3]  = '{centre(-10), fill(1),   -10,    1'b0, -10,  1'b0, -2,     1'b0};
      vecs[4]  = '{fill(127),   fill(255), 32767,  1'b1, 127,  1'b1, 32767,  1'b1};
      vecs[5]  = '{mc,          mp,        600,    1'b0, 127,  1'b1, 150,    1'b0};
      vecs[6]  = '{centre(-1),  fill(129), -129,   1'b0, -128, 1'b1, -32,    1'b0};
      vecs[7]  = '{centre(-1),  fill(128), -128,   1'b0, -128, 1'b0, -32,    1'b0};
      vecs[8]  = '{centre(1),   fill(127), 127,    1'b0, 127,  1'b0, 32,     1'b0};
      vecs[9]  = '{centre(1),   fill(128), 128,    1'b0, 127,  1'b1, 32,     1'b0};
      vecs[10] = '{centre(6),   fill(1),   6,      1'b0, 6,    1'b0, 2,      1'b0};
      vecs[11] = '{centre(-6),  fill(1),   -6,     1'b0, -6,   1'b0, -1,     1'b0};

      // Reset state
      do_reset();
      chk("rst out_valid", int'(out_valid_a), 0);
      chk("rst result", int'(result_a), 0);
      chk("rst out_last", int'(out_last_a), 0);
      chk("rst sat", int'(sat_a), 0);
      chk("rst win_ready", int'(win_ready_a), 1);

      // Single-window vectors across three configurations
      for (int i = 0; i < 12; i++) apply_vec(i);

      // Back-to-back stream with out_ready 1,0,0,... across a frame boundary
      do_reset();
      load_coef(fill(1));
      run_stream(50, 3);

      // Coefficient load coinciding with acceptance of window A
      out_ready = 1'b1;
      window_in = fill(2); win_valid = 1'b1;
      filt_in = fill(2); filt_load = 1'b1;
      @(posedge clk); #1;
      filt_load = 1'b0;
      window_in = fill(2); win_valid = 1'b1;
      @(posedge clk); #1;
      win_valid = 1'b0;
      ng = 0; cyc = 0;
      while (ng < 2 && cyc < 20) begin
         if (out_valid_a) begin
            got[ng] = int'($signed(result_a));
            ng++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("coef swap count", ng, 2);
      if (ng == 2) begin
         chk("coef swap A old", got[0], 18);
         chk("coef swap B new", got[1], 36);
      end

      // Reset with three windows in flight
      load_coef(fill(1));
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         window_in = fill(3); win_valid = 1'b1;
         @(posedge clk); #1;
      end
      win_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst out_valid", int'(out_valid_a), 0);
      chk("midrst result", int'(result_a), 0);
      stale = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid_a) stale = 1'b1;
         @(posedge clk); #1;
      end
      chk("midrst no stale", int'(stale), 0);
      load_coef(fill(1));
      run_stream(49, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
